// File: rtl/common.sv
// Shared keyboard/ASCII types, virtual-key codes and the built-in US translation table.
// Latency: n/a (declarations and a constant function only).
// Backpressure: n/a.
package common;

    typedef struct packed {
        logic       is_break;
        logic [7:0] vk;
    } kbd_event_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_LOOKUP = 2'd2,
        S_EMIT   = 2'd3
    } ascii_state_t;

    localparam logic [7:0] VK_CAPSLOCK = 8'h14;
    localparam logic [7:0] VK_LSHIFT   = 8'hA0;
    localparam logic [7:0] VK_RSHIFT   = 8'hA1;
    localparam logic [7:0] VK_LCTRL    = 8'hA2;
    localparam logic [7:0] VK_RCTRL    = 8'hA3;
    localparam logic [7:0] VK_LALT     = 8'hA4;
    localparam logic [7:0] VK_RALT     = 8'hA5;
    localparam logic [7:0] VK_A        = 8'h41;
    localparam logic [7:0] VK_Z        = 8'h5A;

    // Default table entry for address {shift, vk}; 0x00 means "no character".
    function automatic logic [7:0] ascii_default(input logic [8:0] addr);
        logic       sh;
        logic [7:0] vk;
        logic [7:0] ch;
        sh = addr[8];
        vk = addr[7:0];
        ch = 8'h00;
        if (vk >= VK_A && vk <= VK_Z) begin
            ch = sh ? vk : (vk + 8'h20);
        end else if (vk >= 8'h30 && vk <= 8'h39) begin
            if (!sh) begin
                ch = vk;
            end else begin
                case (vk[3:0])
                    4'd0:    ch = 8'h29;
                    4'd1:    ch = 8'h21;
                    4'd2:    ch = 8'h40;
                    4'd3:    ch = 8'h23;
                    4'd4:    ch = 8'h24;
                    4'd5:    ch = 8'h25;
                    4'd6:    ch = 8'h5E;
                    4'd7:    ch = 8'h26;
                    4'd8:    ch = 8'h2A;
                    default: ch = 8'h28;
                endcase
            end
        end else if (vk == 8'h08 || vk == 8'h09 || vk == 8'h0D ||
                     vk == 8'h1B || vk == 8'h20) begin
            ch = vk;
        end
        return ch;
    endfunction

endpackage

// File: rtl/ascii_rom.sv
// Translation table: 512x8 ROM addressed by {shift_eff, vk}.
// Latency: one cycle (registered read data).
// Backpressure: none; a read is performed every cycle.
module ascii_rom
    import common::*;
#(
    parameter string CONTENTS = "arom.mem"
) (
    input  logic       clk_i,
    input  logic [8:0] addr_i,
    output logic [7:0] data_o
);

    logic [7:0] r_mem [0:511];
    logic [7:0] r_data;

    // Table image: built-in US layout
    initial begin
        for (int i = 0; i < 512; i++) begin
            r_mem[i] = ascii_default(9'(i));
        end
    end

    // Registered read port
    always_ff @(posedge clk_i) begin
        r_data <= r_mem[addr_i];
    end

    assign data_o = r_data;

endmodule

// File: rtl/kbd_ascii.sv
// ASCII translator: pops keyboard events, tracks modifier keys, emits characters.
// Latency: event sampled in IDLE at cycle N gives char_valid_o at N+3; one char per 4 cycles.
// Backpressure: a pending char holds EMIT and blocks pops until char_ready_i accepts it.
module kbd_ascii
    import common::*;
#(
    parameter string CONTENTS = "arom.mem"
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [8:0] kbd_data_i,
    input  logic       kbd_valid_i,
    output logic       kbd_read_o,
    output logic [7:0] char_o,
    output logic       char_valid_o,
    input  logic       char_ready_i,
    output logic [3:0] mods_o
);

    ascii_state_t r_state;
    kbd_event_t   r_evt;
    logic         r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt;
    logic         r_caps_down;
    logic         r_caps_lock;
    logic [7:0]   r_char;
    logic         r_char_vld;

    logic         w_shift, w_ctrl, w_alt;
    logic         w_is_letter, w_shift_eff;
    logic [8:0]   w_rom_addr;
    logic [7:0]   w_rom_data;
    logic [7:0]   w_char;

    assign w_shift     = r_lshift | r_rshift;
    assign w_ctrl      = r_lctrl  | r_rctrl;
    assign w_alt       = r_lalt   | r_ralt;
    assign w_is_letter = (r_evt.vk >= VK_A) && (r_evt.vk <= VK_Z);
    // Caps lock only inverts shift for letters; digits and symbols ignore it.
    assign w_shift_eff = w_shift ^ (r_caps_lock & w_is_letter);
    assign w_rom_addr  = {w_shift_eff, r_evt.vk};
    // Ctrl folds the 0x40..0x7F range onto control codes.
    assign w_char      = (w_ctrl && (w_rom_data[7:6] == 2'b01)) ? (w_rom_data & 8'h1F) : w_rom_data;

    ascii_rom #(
        .CONTENTS(CONTENTS)
    ) u_rom (
        .clk_i (clk_i),
        .addr_i(w_rom_addr),
        .data_o(w_rom_data)
    );

    // The pop strobe coincides with the capture edge, so the FIFO head is taken exactly once.
    assign kbd_read_o   = (r_state == S_IDLE) && kbd_valid_i && !reset_i;
    assign char_o       = r_char;
    assign char_valid_o = r_char_vld;
    assign mods_o       = {r_caps_lock, w_alt, w_ctrl, w_shift};

    // Event FSM: capture, decode modifiers, look up the character, hold it until accepted
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_evt       <= '0;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_lctrl     <= 1'b0;
            r_rctrl     <= 1'b0;
            r_lalt      <= 1'b0;
            r_ralt      <= 1'b0;
            r_caps_down <= 1'b0;
            r_caps_lock <= 1'b0;
            r_char      <= 8'h00;
            r_char_vld  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (kbd_valid_i) begin
                        r_evt   <= kbd_event_t'(kbd_data_i);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_state <= S_IDLE;
                    case (r_evt.vk)
                        VK_LSHIFT: r_lshift <= !r_evt.is_break;
                        VK_RSHIFT: r_rshift <= !r_evt.is_break;
                        VK_LCTRL:  r_lctrl  <= !r_evt.is_break;
                        VK_RCTRL:  r_rctrl  <= !r_evt.is_break;
                        VK_LALT:   r_lalt   <= !r_evt.is_break;
                        VK_RALT:   r_ralt   <= !r_evt.is_break;
                        VK_CAPSLOCK: begin
                            // Typematic repeats of the make must not re-toggle
                            if (r_evt.is_break) begin
                                r_caps_down <= 1'b0;
                            end else begin
                                if (!r_caps_down) begin
                                    r_caps_lock <= !r_caps_lock;
                                end
                                r_caps_down <= 1'b1;
                            end
                        end
                        default: begin
                            if (!r_evt.is_break) begin
                                r_state <= S_LOOKUP;
                            end
                        end
                    endcase
                end
                S_LOOKUP: begin
                    if (w_rom_data == 8'h00) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_char     <= w_char;
                        r_char_vld <= 1'b1;
                        r_state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (char_ready_i) begin
                        r_char_vld <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
